// File: rtl/pwm_generator.sv
// ============================================================================
// Module      : pwm_generator
// Description : Fixed-period PWM driver with double-buffered duty, input clamp
//               and a one-clk period-end strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_generator #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 10,
  parameter int PRESC  = 1,
  parameter int SHIFT  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] Duty,
  input  logic        Upd,
  input  logic        En,
  output logic        PwmOut,
  output logic        PeriodEnd,
  output logic        SatHi,
  output logic        SatLo
);

  localparam int              PW        = $clog2(PRESC) + 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PERIOD);
  localparam logic [16:0]     PERIOD_17 = 17'(PERIOD);

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] active;
  logic [16:0]      scaled;
  logic             tick;
  logic             wrap;

  assign scaled = Duty[16:0] >> SHIFT;
  assign tick   = En && (presc == PRESC_MAX);
  assign wrap   = tick && (cnt == CNT_MAX);

  // Shadow register and saturation flags, written only on Upd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      SatHi  <= 1'b0;
      SatLo  <= 1'b0;
    end else if (Upd) begin
      if (Duty[17]) begin
        shadow <= '0;
        SatHi  <= 1'b0;
        SatLo  <= 1'b1;
      end else if (scaled > PERIOD_17) begin
        shadow <= DUTY_MAX;
        SatHi  <= 1'b1;
        SatLo  <= 1'b0;
      end else begin
        shadow <= scaled[CNT_W-1:0];
        SatHi  <= 1'b0;
        SatLo  <= 1'b0;
      end
    end
  end

  // While disabled, active tracks shadow so the first enabled period is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      cnt       <= '0;
      active    <= '0;
      PwmOut    <= 1'b0;
      PeriodEnd <= 1'b0;
    end else if (!En) begin
      presc     <= '0;
      cnt       <= '0;
      active    <= shadow;
      PwmOut    <= 1'b0;
      PeriodEnd <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wrap) begin
        cnt    <= '0;
        active <= shadow;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
      PwmOut    <= (cnt < active);
      PeriodEnd <= wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_generator.sv
// ============================================================================
// Module      : tb_pwm_generator
// Description : Scoreboard bench for pwm_generator (PRESC=1 and PRESC=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_generator;

  typedef struct {
    int hi;
    int len;
  } per_t;

  logic        clk;
  logic        rst;
  logic [17:0] Duty;
  logic        Upd;
  logic        en1;
  logic        en4;
  logic        pwm_1, pe_1, sathi_1, satlo_1;
  logic        pwm_4, pe_4, sathi_4, satlo_4;

  per_t        q1[$];
  per_t        q4[$];
  logic [1:0]  qf[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  acc_hi1, acc_len1, acc_hi4, acc_len4;
  bit  final_req = 0;
  bit  final_done = 0;
  bit  aborted = 0;

  pwm_generator #(.PERIOD(1000), .CNT_W(10), .PRESC(1), .SHIFT(7)) dut1 (
    .clk(clk), .rst(rst), .Duty(Duty), .Upd(Upd), .En(en1),
    .PwmOut(pwm_1), .PeriodEnd(pe_1), .SatHi(sathi_1), .SatLo(satlo_1)
  );

  pwm_generator #(.PERIOD(1000), .CNT_W(10), .PRESC(4), .SHIFT(7)) dut4 (
    .clk(clk), .rst(rst), .Duty(Duty), .Upd(Upd), .En(en4),
    .PwmOut(pwm_4), .PeriodEnd(pe_4), .SatHi(sathi_4), .SatLo(satlo_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples 1ns after each clk edge, and 1ns after any reset assertion.
  always @(posedge clk or negedge rst) begin
    per_t       e;
    logic [1:0] f;
    #1;
    if (!rst) begin
      check("reset_outputs_dut1", int'({pwm_1, pe_1, sathi_1, satlo_1}), 0);
      check("reset_outputs_dut4", int'({pwm_4, pe_4, sathi_4, satlo_4}), 0);
      acc_hi1 = 0; acc_len1 = 0; acc_hi4 = 0; acc_len4 = 0;
    end else begin
      if (Upd) begin
        check("flag_expected", int'(qf.size() > 0), 1);
        if (qf.size() > 0) begin
          f = qf.pop_front();
          check("sat_flags_dut1", int'({sathi_1, satlo_1}), int'(f));
        end
      end
      if (!en1) begin
        acc_hi1 = 0; acc_len1 = 0;
      end else begin
        acc_hi1  += int'(pwm_1);
        acc_len1 += 1;
        if (pe_1) begin
          check("period_expected_dut1", int'(q1.size() > 0), 1);
          if (q1.size() > 0) begin
            e = q1.pop_front();
            check("period_high_dut1", acc_hi1, e.hi);
            check("period_len_dut1", acc_len1, e.len);
          end
          acc_hi1 = 0; acc_len1 = 0;
        end
      end
      if (!en4) begin
        acc_hi4 = 0; acc_len4 = 0;
      end else begin
        acc_hi4  += int'(pwm_4);
        acc_len4 += 1;
        if (pe_4) begin
          check("period_expected_dut4", int'(q4.size() > 0), 1);
          if (q4.size() > 0) begin
            e = q4.pop_front();
            check("period_high_dut4", acc_hi4, e.hi);
            check("period_len_dut4", acc_len4, e.len);
          end
          acc_hi4 = 0; acc_len4 = 0;
        end
      end
      if (final_req && !final_done) begin
        check("leftover_periods_dut1", q1.size(), 0);
        check("leftover_periods_dut4", q4.size(), 0);
        check("leftover_flags", qf.size(), 0);
        final_done = 1;
      end
    end
  end

  task automatic push_per(input int which, input int hi, input int len);
    per_t p;
    p.hi  = hi;
    p.len = len;
    if (which == 1) q1.push_back(p);
    else            q4.push_back(p);
  endtask

  // Called at a negedge; Upd is seen by exactly the next posedge.
  task automatic upd_now(input logic [17:0] d, input logic [1:0] flags);
    Duty = d;
    Upd  = 1'b1;
    qf.push_back(flags);
    @(negedge clk);
    Upd  = 1'b0;
  endtask

  task automatic wait_q(input int which, input int budget);
    int sz;
    sz = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      sz = (which == 1) ? q1.size() : q4.size();
      if (sz == 0) break;
    end
    if (sz != 0) begin
      $display("FAIL wait_periods_dut%0d: %0d periods pending, required 0", which, sz);
      aborted = 1;
    end
  endtask

  // Load 250 while idle, enable, optionally update at edge k of the run,
  // and score three periods.
  task automatic run_phase(input int k, input logic [17:0] d1, input logic [1:0] f1,
                           input int e0, input int e1, input int e2);
    @(negedge clk);
    upd_now(18'd32000, 2'b00);
    push_per(1, e0, 1000);
    push_per(1, e1, 1000);
    push_per(1, e2, 1000);
    @(negedge clk);
    en1 = 1'b1;
    if (k >= 0) begin
      repeat (k) @(negedge clk);
      upd_now(d1, f1);
    end
    wait_q(1, 3200);
    @(negedge clk);
    en1 = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    en1  = 1'b1;
    en4  = 1'b0;
    Duty = 18'd32000;
    Upd  = 1'b0;
    repeat (5) @(negedge clk);

    // After release with no Upd the output stays low for three periods.
    push_per(1, 0, 1000);
    push_per(1, 0, 1000);
    push_per(1, 0, 1000);
    rst = 1'b1;
    wait_q(1, 3200);
    @(negedge clk);
    en1 = 1'b0;

    if (!aborted) run_phase(-1,  18'd0,      2'b00, 250, 250, 250);
    if (!aborted) run_phase(100, 18'h3FF00,  2'b01, 250, 0,    0);
    if (!aborted) run_phase(100, 18'd131071, 2'b10, 250, 1000, 1000);
    if (!aborted) run_phase(100, 18'd64000,  2'b00, 250, 500,  500);
    if (!aborted) run_phase(999, 18'd64000,  2'b00, 250, 250,  500);

    if (!aborted) begin
      @(negedge clk);
      upd_now(18'd32000, 2'b00);
      push_per(4, 1000, 4000);
      push_per(4, 1000, 4000);
      @(negedge clk);
      en4 = 1'b1;
      wait_q(4, 8200);
    end

    if (!aborted) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (pwm_4) break;
      end
      #2;
      rst = 1'b0;
      @(negedge clk);
      en4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end

    @(negedge clk);
    en1 = 1'b0;
    en4 = 1'b0;
    final_req = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
Downstream consumer of the controller register bank's 18-bit PWM register (t2). The block converts the signed controller output into a fixed-period, glitch-free pulse-width-modulated drive signal. It double-buffers the duty value so that updates only take effect at a period boundary. It also emits a period-end strobe that the controller sequencer uses to start the next control sample.

Parameters:
PERIOD, 1000, PWM period in ticks (count range 0..PERIOD-1)
CNT_W, 10, period counter width; must hold PERIOD
PRESC, 1, clk cycles per tick (1 = every clk); prescaler width is $clog2(PRESC)+1
SHIFT, 7, right-shift applied to the non-negative 18-bit input to obtain the duty in ticks

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low (0 = reset)
Duty  input  18  signed two's-complement controller output (PWM register value)
Upd  input  1  one-cycle strobe: capture Duty into the shadow register
En  input  1  output enable; low = counters held, output low
PwmOut  output  1  registered PWM drive
PeriodEnd  output  1  one-clk pulse at each period wrap
SatHi  output  1  last captured Duty was clamped to PERIOD
SatLo  output  1  last captured Duty was negative and clamped to 0

Behaviour:
- Reset (rst=0, asynchronous): prescaler, counter, shadow, active duty, PwmOut, PeriodEnd, SatHi and SatLo all go to 0 immediately. The output stays low after release until a nonzero duty is captured and loaded.
- Clamp on Upd (registered, 1-cycle):
  - Duty[17]=1: shadow<=0, SatLo<=1, SatHi<=0.
  - Otherwise, with s = Duty>>SHIFT (logical, 17 significant bits): if s>PERIOD then shadow<=PERIOD, SatHi<=1; else shadow<=s, SatHi<=0. SatLo<=0 in both cases.
  - Flags hold their value until the next Upd.
- Prescaler: counts 0..PRESC-1 while En=1. tick=1 when it equals PRESC-1, then it wraps to 0. With PRESC=1, tick=1 every clk.
- Period counter cnt: on tick, increments; at PERIOD-1 it wraps to 0 (the wrap tick).
- Active duty: loaded from shadow only on the wrap tick. Mid-period Upd never changes the current period.
- Upd on the same clk as the wrap tick: the wrap loads the old shadow; the new value applies one period later.
- PwmOut <= En && (cnt < active), registered, so it lags cnt by one clk. Boundary cases:
  - active=0: always low.
  - active=PERIOD: always high.
  - Each period has exactly active×PRESC high clk cycles.
- PeriodEnd <= wrap tick (registered). It is high for exactly one clk per period, including when PRESC>1.
- En=0:
  - prescaler and cnt are cleared to 0; PwmOut<=0 and PeriodEnd<=0;
  - active<=shadow every clk, so the first period after En rises uses the latest shadow;
  - Upd is still honoured.
- En rising: counting starts at cnt=0 on that clk. The first PwmOut high appears one clk later if active>0.
- rst asserted mid-period: the output drops asynchronously, with no completion of the period.

Test Plan:
- Reset: hold rst=0 with En=1 and Duty=18'd32000. Required: PwmOut=0, PeriodEnd=0, SatHi=SatLo=0. After release with no Upd, PwmOut stays 0 for 3000 clks.
- Nominal: PRESC=1, Duty=18'd32000 (s=250), Upd pulse, then En=1. Required: every period shows 250 high and 750 low clks, and PeriodEnd pulses every 1000 clks.
- Negative: Duty=18'h3FF00 plus Upd. Required: SatLo=1 and SatHi=0 on the next clk; PwmOut constant 0 from the next period.
- Overrange: Duty=18'd131071 (s=1023) plus Upd. Required: SatHi=1; PwmOut constant 1 from the next period; PeriodEnd still pulses every 1000 clks.
- Mid-period update: running at 250, Upd with Duty=18'd64000 (s=500) at cnt=100, and again with the same value coinciding with a wrap tick. Required: the current period has 250 high clks; the next period has 500 (or the following one, in the wrap-collision case).
- Prescaler and mid-period reset: PRESC=4 with s=250. Required: 1000 high of 4000 clks and a 1-clk PeriodEnd. Then pulse rst=0 while PwmOut=1. Required: PwmOut=0 within the same cycle, not at the next clk edge.
